mp_add_sequencer: RTL

- Multi-precision add/subtract sequencer that sits directly upstream of the 32-bit prefix adder and also consumes its result.
- It streams N-word operands, least-significant word first, through one external 32-bit adder instance. Each word's carry-out is registered and fed back as the next word's carry-in.
- It registers each result word onto a valid/ready output stream. On the final word it reports carry-out and signed overflow.

---
 rtl/mp_add_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer.
// Streams N-word operands (least-significant word first) through one external
// 32-bit adder, chaining the carry between words, and registers each result
// word onto a valid/ready output stream with carry-out and signed overflow on
// the most-significant word.
//
// Handshake rules (both streams): a beat transfers on a rising edge where
// valid & ready are both high. A producer holds valid and its payload steady
// until the transfer. in_ready never looks at in_valid. The output side is a
// single register with no skid buffer: in_ready = ~out_valid | out_ready.
module mp_add_sequencer #(
  parameter int MAX_WORDS = 16,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_sub,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_cin,
  input  logic [31:0]      add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             err,
  output logic             dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_WORDS - 1);

  state_t           state_q;
  state_t           state_d;
  logic             carry_q;
  logic             sub_q;
  logic [IDX_W-1:0] count_q;

  logic             sub_eff;
  logic             accept;
  logic             data_acc;
  logic             err_d;
  logic             eff_last;
  logic             limit_hit;
  logic [IDX_W-1:0] idx_cur;

  assign dbg_state = state_q;

  // Output register frees up when empty or being drained this cycle.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // First word of an operation takes its mode straight from the input;
  // later words use the mode latched on the first word.
  assign sub_eff = in_first ? in_sub : sub_q;
  assign add_a   = in_a;
  assign add_b   = sub_eff ? ~in_b : in_b;
  assign add_cin = in_first ? in_sub : carry_q;

  // Next-state and per-beat classification: stray word, restart, word limit.
  always_comb begin
    state_d   = state_q;
    data_acc  = 1'b0;
    err_d     = 1'b0;
    eff_last  = 1'b0;
    limit_hit = 1'b0;
    idx_cur   = in_first ? '0 : count_q;
    if (accept) begin
      if ((state_q == IDLE) && !in_first) begin
        // Word outside any operation: swallowed, flagged, no output.
        err_d = 1'b1;
      end else begin
        data_acc  = 1'b1;
        limit_hit = (idx_cur == LAST_IDX) & ~in_last;
        eff_last  = in_last | limit_hit;
        err_d     = ((state_q == BUSY) & in_first) | limit_hit;
        state_d   = eff_last ? IDLE : BUSY;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Carry chain, mode and word counter; all hold while no data word is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      count_q <= '0;
    end else if (data_acc) begin
      carry_q <= add_cout;
      count_q <= idx_cur + 1'b1;
      if (in_first) begin
        sub_q <= in_sub;
      end
    end
  end

  // Result word register and single-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= err_d;
      if (data_acc) begin
        out_valid <= 1'b1;
        out_sum   <= add_sum;
        out_idx   <= idx_cur;
        out_last  <= eff_last;
        if (eff_last) begin
          out_cout <= add_cout;
          out_ovf  <= (in_a[31] == add_b[31]) & (add_sum[31] != in_a[31]);
        end
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
